mem_arbiter: RTL

Single-port memory arbiter sitting between the system RAM controller and its three requesters: ROM/data download (ioctl), video DMA read channel, and CPU. It replaces the top-level combinational address/strobe mux with a sequenced request/acknowledge scheme. It issues one access at a time, captures read data after a fixed RAM latency, and enforces fixed priority with a CPU anti-starvation guard.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for download, video DMA and CPU requesters.
// Serialises accesses one at a time with fixed priority and a CPU anti-starvation guard.
module mem_arbiter #(
    parameter int AW           = 25,
    parameter int MEM_LAT      = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_req,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_wdata,
    output logic          dl_ack,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic          dma_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic [7:0]    rdata,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [7:0]    mem_dout
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int RW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_DL, OWN_DMA, OWN_CPU} owner_t;

    state_t        r_state;
    owner_t        r_owner;
    logic          r_we;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_dma_run;
    logic          r_dl_ack, r_dma_ack, r_cpu_ack;
    logic          r_mem_we, r_mem_rd;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_mem_din, r_rdata;

    logic w_dma_ok, w_cpu_ok, w_cpu_force, w_gnt_dma, w_gnt_cpu;

    // A pending download locks out everyone else; the CPU jumps DMA once DMA has had its run.
    assign w_dma_ok    = dma_req & ~dl_active;
    assign w_cpu_ok    = cpu_req & ~dl_active;
    assign w_cpu_force = w_cpu_ok && (r_dma_run == RW'(STARVE_LIMIT));
    assign w_gnt_dma   = ~dl_req & w_dma_ok & ~w_cpu_force;
    assign w_gnt_cpu   = ~dl_req & (w_cpu_force | (w_cpu_ok & ~w_dma_ok));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner    <= OWN_DL;
            r_we       <= 1'b0;
            r_cnt      <= '0;
            r_dma_run  <= '0;
            r_dl_ack   <= 1'b0;
            r_dma_ack  <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_rdata    <= '0;
        end else begin
            r_dl_ack  <= 1'b0;
            r_dma_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_rd  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!cpu_req) r_dma_run <= '0;
                    // Strobes are launched at the grant edge so they are high during ISSUE.
                    if (dl_req) begin
                        r_owner    <= OWN_DL;
                        r_we       <= 1'b1;
                        r_mem_addr <= dl_addr;
                        r_mem_din  <= dl_wdata;
                        r_mem_we   <= 1'b1;
                        r_state    <= S_ISSUE;
                    end else if (w_gnt_dma) begin
                        r_owner    <= OWN_DMA;
                        r_we       <= 1'b0;
                        r_mem_addr <= dma_addr;
                        r_mem_rd   <= 1'b1;
                        r_state    <= S_ISSUE;
                        if (cpu_req && r_dma_run != RW'(STARVE_LIMIT))
                            r_dma_run <= r_dma_run + RW'(1);
                    end else if (w_gnt_cpu) begin
                        r_owner    <= OWN_CPU;
                        r_we       <= cpu_we;
                        r_mem_addr <= cpu_addr;
                        r_mem_din  <= cpu_wdata;
                        r_mem_we   <= cpu_we;
                        r_mem_rd   <= ~cpu_we;
                        r_dma_run  <= '0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == CW'(MEM_LAT - 1)) begin
                        if (!r_we) r_rdata <= mem_dout;
                        r_dl_ack  <= (r_owner == OWN_DL);
                        r_dma_ack <= (r_owner == OWN_DMA);
                        r_cpu_ack <= (r_owner == OWN_CPU);
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dl_ack   = r_dl_ack;
    assign dma_ack  = r_dma_ack;
    assign cpu_ack  = r_cpu_ack;
    assign rdata    = r_rdata;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_we   = r_mem_we;
    assign mem_rd   = r_mem_rd;

endmodule
